ps_bc_slct_seq: RTL
===================

Name: ps_bc_slct_seq

Overview:
- Parametrised successor to the decode-stage bus-connect select control.
- Decodes instruction class and universal-register addresses into the DRR bus select and the DI select.
- Delivers DI select through a configurable-depth registered pipeline with stall/hold support.
- Adds a two-beat sequencer for double-word (DBL) transfers, plus optional illegal-class detection.
- Sits in the program sequencer decode stage and drives the bus-connect (bc) mux controls.

Parameters:
UREG_AW, 4, width of universal-register address fields
DI_LAT, 1, number of register stages on the DI select path (legal range 1..4)
DRF_ADDR, 0, ureg address selecting the data-register-file group (DRR code 2'b10)
STK_LO, 6, low address of the stack/PC group (DRR code 2'b01)
STK_HI, 7, high address of the stack/PC group (DRR code 2'b01)
DAG_LO, 1, low address of the DAG group (DRR code 2'b00)
DAG_HI, 2, high address of the DAG group (DRR code 2'b00)

Ports:
clk_dcd  in  1  decode clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
ps_hold  in  1  pipeline hold; freezes the FSM and the DI pipe
ps_imminst  in  1  immediate-load instruction
ps_popstck  in  1  stack pop
ps_pshstck  in  1  stack push
ps_dminst  in  1  data-memory instruction
ps_dm_wrb  in  1  DM direction: 1 = write, 0 = read
ps_urgtrnsinst  in  1  ureg-to-ureg transfer
ps_dbl  in  1  double-word (two-beat) transfer
ps_ureg1_add  in  UREG_AW  source ureg for DM write / push
ps_ureg2_add  in  UREG_AW  source ureg for ureg transfer
ps_bc_drr_slct  out  2  DRR bus select (combinational)
ps_bc_di_slct  out  2  DI select, DI_LAT cycles late
ps_bc_stall  out  1  request to decode to hold the current instruction
ps_bc_beat  out  1  beat index of the current transfer (0/1)
ps_bc_err  out  1  sticky illegal-class flag (only with the optional feature)

Behaviour:
- Class priority, highest first: imminst, popstck, DM read (dminst & !dm_wrb), DM write or push ((dminst & dm_wrb) | pshstck), urgtrnsinst, none.
- Group decode, applied to addr A:
  - A==DRF_ADDR -> 2'b10
  - STK_LO<=A<=STK_HI -> 2'b01
  - DAG_LO<=A<=DAG_HI -> 2'b00
  - otherwise -> 2'b11
- Per class, DRR / DI-next:
  - imminst: 11 / 10
  - popstck: 01 / 01
  - DM read: 11 / 00
  - DM write/push: group(ureg1) / 01
  - urgtrns: group(ureg2) / 01
  - none: 11 / 11
- ps_bc_drr_slct is purely combinational from the current inputs; no latency.
- DI pipe: a DI_LAT-deep shift register holding DI-next.
  - Shifts on every clk_dcd edge with ps_hold=0; holds contents with ps_hold=1.
  - ps_bc_di_slct is the last stage.
- FSM states: IDLE, BEAT1.
  - IDLE: ps_bc_beat=0. If ps_dbl=1 and the class is popstck, DM read, DM write/push or urgtrns: ps_bc_stall=1, and the next unheld edge moves to BEAT1.
  - imminst with ps_dbl=1 is single-beat: no stall, stays in IDLE.
  - BEAT1: ps_bc_beat=1, ps_bc_stall=0. Decode re-presents the same instruction, and the DRR/DI decode repeats. The next unheld edge returns to IDLE, regardless of ps_dbl.
  - ps_hold=1 freezes the state. ps_bc_stall and ps_bc_beat keep their combinational values.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all DI stages=2'b11; ps_bc_err=0.
  - Outputs during reset: ps_bc_di_slct=11, ps_bc_beat=0. ps_bc_stall and ps_bc_drr_slct follow the combinational decode.
  - Reset while in BEAT1 aborts the second beat.
- Simultaneous class bits are resolved by priority; no other side effect unless the optional feature is enabled.

Optional Feature:
- Macro: PS_BC_ERR_EN.
- Defined:
  - ps_bc_err is set on an unheld edge when two or more of imminst, popstck, pshstck, dminst, urgtrnsinst are 1.
  - It stays set until reset.
- Undefined: ps_bc_err is tied to 0 and no detection logic is built.

Test Plan:
1. Reset with DI_LAT=2, then release with all class bits 0 -> ps_bc_di_slct=11, ps_bc_drr_slct=11, beat=0, stall=0.
2. dminst=1, dm_wrb=1, ureg1_add=4'h6 -> drr=01 same cycle; di_slct=01 after exactly DI_LAT edges. Repeat with ureg1_add=4'h2 -> drr=00.
3. popstck=1, ps_dbl=1 -> cycle0: stall=1, beat=0; cycle1: stall=0, beat=1, drr=01; cycle2: back in IDLE.
4. ps_hold=1 for 3 cycles while in BEAT1 after an urgtrns with ureg2_add=0 -> beat stays 1, drr=10, di pipe frozen; the FSM leaves BEAT1 on the first unheld edge.
5. imminst=1 and popstck=1 together -> drr=11, DI-next=10. ps_bc_err=1 next edge with PS_BC_ERR_EN defined; 0 without it.
6. Assert rst_n=0 mid-BEAT1 -> beat=0 and di_slct=11 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ps_bc_slct_seq.sv
// Decode-stage bus-connect select: DRR/DI select decode, DI_LAT-deep DI pipe, two-beat DBL sequencer.
// Optional sticky illegal-class detection when PS_BC_ERR_EN is defined.
module ps_bc_slct_seq #(
  parameter int UREG_AW  = 4,
  parameter int DI_LAT   = 1,
  parameter int DRF_ADDR = 0,
  parameter int STK_LO   = 6,
  parameter int STK_HI   = 7,
  parameter int DAG_LO   = 1,
  parameter int DAG_HI   = 2
) (
  input  logic               clk_dcd,
  input  logic               rst_n,
  input  logic               ps_hold,
  input  logic               ps_imminst,
  input  logic               ps_popstck,
  input  logic               ps_pshstck,
  input  logic               ps_dminst,
  input  logic               ps_dm_wrb,
  input  logic               ps_urgtrnsinst,
  input  logic               ps_dbl,
  input  logic [UREG_AW-1:0] ps_ureg1_add,
  input  logic [UREG_AW-1:0] ps_ureg2_add,
  output logic [1:0]         ps_bc_drr_slct,
  output logic [1:0]         ps_bc_di_slct,
  output logic               ps_bc_stall,
  output logic               ps_bc_beat,
  output logic               ps_bc_err
);

  localparam logic [UREG_AW-1:0] DRF_A = UREG_AW'(DRF_ADDR);
  localparam logic [UREG_AW-1:0] STK_L = UREG_AW'(STK_LO);
  localparam logic [UREG_AW-1:0] STK_H = UREG_AW'(STK_HI);
  localparam logic [UREG_AW-1:0] DAG_L = UREG_AW'(DAG_LO);
  localparam logic [UREG_AW-1:0] DAG_H = UREG_AW'(DAG_HI);

  typedef enum logic {IDLE = 1'b0, BEAT1 = 1'b1} state_t;

  function automatic logic [1:0] grp_dec(input logic [UREG_AW-1:0] a);
    if (a == DRF_A)                    return 2'b10;
    else if (a >= STK_L && a <= STK_H) return 2'b01;
    else if (a >= DAG_L && a <= DAG_H) return 2'b00;
    else                               return 2'b11;
  endfunction

  state_t     state;
  logic       beat_q;
  logic [1:0] di_nxt;
  logic       two_beat;
  logic       cls_rd;
  logic       cls_wr;
  logic [1:0] di_pipe [DI_LAT];

  assign cls_rd = ps_dminst & ~ps_dm_wrb;
  assign cls_wr = (ps_dminst & ps_dm_wrb) | ps_pshstck;

  // Stage 0: combinational class priority decode
  always_comb begin
    ps_bc_drr_slct = 2'b11;
    di_nxt         = 2'b11;
    two_beat       = 1'b0;
    if (ps_imminst) begin
      di_nxt = 2'b10;
    end else if (ps_popstck) begin
      ps_bc_drr_slct = 2'b01;
      di_nxt         = 2'b01;
      two_beat       = 1'b1;
    end else if (cls_rd) begin
      di_nxt   = 2'b00;
      two_beat = 1'b1;
    end else if (cls_wr) begin
      ps_bc_drr_slct = grp_dec(ps_ureg1_add);
      di_nxt         = 2'b01;
      two_beat       = 1'b1;
    end else if (ps_urgtrnsinst) begin
      ps_bc_drr_slct = grp_dec(ps_ureg2_add);
      di_nxt         = 2'b01;
      two_beat       = 1'b1;
    end
  end

  assign ps_bc_stall = (state == IDLE) & ps_dbl & two_beat;
  assign ps_bc_beat  = beat_q;

  // Beat sequencer: BEAT1 always returns to IDLE on the next unheld edge
  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat_q <= 1'b0;
    end else if (!ps_hold) begin
      case (state)
        IDLE: begin
          if (ps_dbl && two_beat) begin
            state  <= BEAT1;
            beat_q <= 1'b1;
          end
        end
        BEAT1: begin
          state  <= IDLE;
          beat_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          beat_q <= 1'b0;
        end
      endcase
    end
  end

  // Stages 1..DI_LAT: DI select shift register, frozen while held
  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DI_LAT; i++) di_pipe[i] <= 2'b11;
    end else if (!ps_hold) begin
      di_pipe[0] <= di_nxt;
      for (int i = 1; i < DI_LAT; i++) di_pipe[i] <= di_pipe[i-1];
    end
  end

  assign ps_bc_di_slct = di_pipe[DI_LAT-1];

`ifdef PS_BC_ERR_EN
  logic       err_q;
  logic [2:0] cls_cnt;

  assign cls_cnt = 3'(ps_imminst) + 3'(ps_popstck) + 3'(ps_pshstck)
                 + 3'(ps_dminst) + 3'(ps_urgtrnsinst);

  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (!ps_hold && cls_cnt >= 3'd2) begin
      err_q <= 1'b1;
    end
  end

  assign ps_bc_err = err_q;
`else
  assign ps_bc_err = 1'b0;
`endif

endmodule
